ps2_scan_receiver: RTL



---
 rtl/ps2_pkg.sv | 19 +
 rtl/ps2_line_filter.sv | 62 ++++++
 rtl/ps2_scan_receiver.sv | 165 ++++++++++++++++
 3 files changed

// File: rtl/ps2_pkg.sv
// ps2_pkg: shared types and constants for the PS/2 scan-code receiver.
//   state_t        : receive FSM states (IDLE, DATA, PARITY, STOP)
//   PS2_BREAK_CODE : key-release prefix byte
//   PS2_EXT_CODE   : extended-key prefix byte (always passed through)
//   PS2_DATA_BITS  : data bits per frame
package ps2_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DATA   = 2'd1,
        PARITY = 2'd2,
        STOP   = 2'd3
    } state_t;

    localparam logic [7:0] PS2_BREAK_CODE = 8'hF0;
    localparam logic [7:0] PS2_EXT_CODE   = 8'hE0;
    localparam int         PS2_DATA_BITS  = 8;

endpackage

// File: rtl/ps2_line_filter.sv
// ps2_line_filter: conditions the raw PS/2 pins for the receive FSM.
//   clk, reset   : system clock, synchronous active-high reset
//   ps2_clk      : raw PS/2 clock pin (asynchronous)
//   ps2_data     : raw PS/2 data pin (asynchronous)
//   strobe       : high for the one cycle in which the filtered clock falls
//   sample_data  : synchronized ps2_data captured on that same falling edge
// Both pins pass through a 2-flop synchronizer. The filtered clock only
// changes level after FILTER_LEN consecutive synchronized samples disagree
// with it, so short glitches on the cable never reach the FSM.
module ps2_line_filter #(
    parameter int FILTER_LEN = 8
) (
    input  logic clk,
    input  logic reset,
    input  logic ps2_clk,
    input  logic ps2_data,
    output logic strobe,
    output logic sample_data
);

    localparam int CW = $clog2(FILTER_LEN + 1);

    logic          clk_s1, clk_s2;
    logic          data_s1, data_s2;
    logic          filt_clk;
    logic [CW-1:0] filt_cnt;

    always_ff @(posedge clk) begin
        if (reset) begin
            clk_s1      <= 1'b1;
            clk_s2      <= 1'b1;
            data_s1     <= 1'b1;
            data_s2     <= 1'b1;
            filt_clk    <= 1'b1;
            filt_cnt    <= '0;
            strobe      <= 1'b0;
            sample_data <= 1'b1;
        end else begin
            clk_s1  <= ps2_clk;
            clk_s2  <= clk_s1;
            data_s1 <= ps2_data;
            data_s2 <= data_s1;
            strobe  <= 1'b0;
            if (clk_s2 != filt_clk) begin
                // This sample is the FILTER_LEN-th consecutive disagreement.
                if (filt_cnt == CW'(FILTER_LEN - 1)) begin
                    filt_clk <= clk_s2;
                    filt_cnt <= '0;
                    if (filt_clk) begin
                        strobe      <= 1'b1;
                        sample_data <= data_s2;
                    end
                end else begin
                    filt_cnt <= filt_cnt + CW'(1);
                end
            end else begin
                filt_cnt <= '0;
            end
        end
    end

endmodule

// File: rtl/ps2_scan_receiver.sv
// ps2_scan_receiver: PS/2 device-to-host frame receiver.
//   clk, reset      : system clock, synchronous active-high reset
//   ps2_clk/ps2_data: raw PS/2 pins (asynchronous to clk)
//   scan_code       : last correctly received byte, held between frames
//   scan_code_ready : one-cycle pulse, scan_code has just been updated
//   parity_err      : one-cycle pulse, frame dropped on bad odd parity
//   frame_err       : one-cycle pulse, frame dropped on bad stop bit/timeout
// Handshake: scan_code_ready acts as a valid strobe with no ready/back-
// pressure; the consumer must capture scan_code in the pulse cycle (it stays
// stable afterwards until the next good byte).
// Build option PS2_BREAK_FILTER_EN: swallow F0 and the byte that follows it
// so key releases are not reported.
// The FSM state is visible as the internal signal "state" for checkers.
module ps2_scan_receiver
    import ps2_pkg::*;
#(
    parameter int FILTER_LEN     = 8,
    parameter int TIMEOUT_CYCLES = 50_000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       ps2_clk,
    input  logic       ps2_data,
    output logic [7:0] scan_code,
    output logic       scan_code_ready,
    output logic       parity_err,
    output logic       frame_err
);

    localparam int TW = $clog2(TIMEOUT_CYCLES);

    logic strobe;
    logic sample_data;

    ps2_line_filter #(
        .FILTER_LEN (FILTER_LEN)
    ) u_filter (
        .clk         (clk),
        .reset       (reset),
        .ps2_clk     (ps2_clk),
        .ps2_data    (ps2_data),
        .strobe      (strobe),
        .sample_data (sample_data)
    );

    state_t        state, state_nxt;
    logic [2:0]    bit_cnt, bit_cnt_nxt;
    logic [7:0]    shreg, shreg_nxt;
    logic          parity_bit, parity_nxt;
    logic [TW-1:0] tmo_cnt, tmo_nxt;
    logic [7:0]    code_nxt;
    logic          ready_nxt, perr_nxt, ferr_nxt;
`ifdef PS2_BREAK_FILTER_EN
    logic          break_pending, break_nxt;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            state           <= IDLE;
            bit_cnt         <= '0;
            shreg           <= '0;
            parity_bit      <= 1'b0;
            tmo_cnt         <= '0;
            scan_code       <= 8'h00;
            scan_code_ready <= 1'b0;
            parity_err      <= 1'b0;
            frame_err       <= 1'b0;
`ifdef PS2_BREAK_FILTER_EN
            break_pending   <= 1'b0;
`endif
        end else begin
            state           <= state_nxt;
            bit_cnt         <= bit_cnt_nxt;
            shreg           <= shreg_nxt;
            parity_bit      <= parity_nxt;
            tmo_cnt         <= tmo_nxt;
            scan_code       <= code_nxt;
            scan_code_ready <= ready_nxt;
            parity_err      <= perr_nxt;
            frame_err       <= ferr_nxt;
`ifdef PS2_BREAK_FILTER_EN
            break_pending   <= break_nxt;
`endif
        end
    end

    always_comb begin
        state_nxt   = state;
        bit_cnt_nxt = bit_cnt;
        shreg_nxt   = shreg;
        parity_nxt  = parity_bit;
        // Timeout counter only runs while a frame is in progress.
        tmo_nxt     = (state == IDLE) ? '0 : tmo_cnt + TW'(1);
        code_nxt    = scan_code;
        ready_nxt   = 1'b0;
        perr_nxt    = 1'b0;
        ferr_nxt    = 1'b0;
`ifdef PS2_BREAK_FILTER_EN
        break_nxt   = break_pending;
`endif

        if (strobe) begin
            tmo_nxt = '0;
            case (state)
                IDLE: begin
                    // A falling edge with data high is a stray edge, not a start bit.
                    if (!sample_data) begin
                        state_nxt   = DATA;
                        bit_cnt_nxt = '0;
                    end
                end
                DATA: begin
                    shreg_nxt   = {sample_data, shreg[7:1]};
                    bit_cnt_nxt = bit_cnt + 3'd1;
                    if (bit_cnt == 3'(PS2_DATA_BITS - 1)) begin
                        state_nxt = PARITY;
                    end
                end
                PARITY: begin
                    parity_nxt = sample_data;
                    state_nxt  = STOP;
                end
                STOP: begin
                    state_nxt = IDLE;
                    if (!sample_data) begin
                        // Bad stop bit wins over a parity error.
                        ferr_nxt = 1'b1;
`ifdef PS2_BREAK_FILTER_EN
                        break_nxt = 1'b0;
`endif
                    end else if (!(^{shreg, parity_bit})) begin
                        perr_nxt = 1'b1;
`ifdef PS2_BREAK_FILTER_EN
                        break_nxt = 1'b0;
`endif
                    end else begin
`ifdef PS2_BREAK_FILTER_EN
                        if (break_pending) begin
                            // Released key code: consumed silently.
                            break_nxt = 1'b0;
                        end else if (shreg == PS2_BREAK_CODE) begin
                            break_nxt = 1'b1;
                        end else begin
                            code_nxt  = shreg;
                            ready_nxt = 1'b1;
                        end
`else
                        code_nxt  = shreg;
                        ready_nxt = 1'b1;
`endif
                    end
                end
                default: state_nxt = IDLE;
            endcase
        end else if (state != IDLE && tmo_cnt == TW'(TIMEOUT_CYCLES - 1)) begin
            state_nxt = IDLE;
            tmo_nxt   = '0;
            ferr_nxt  = 1'b1;
`ifdef PS2_BREAK_FILTER_EN
            break_nxt = 1'b0;
`endif
        end
    end

endmodule
